// File: rtl/spot_gen_pkg.sv
// Shared constants and helpers for the multi-channel spot generator.
// Channel count is bounded by MAX_SPOTS; the priority encoder is sized for that bound.
package spot_gen_pkg;

  localparam int MAX_SPOTS      = 8;
  localparam int MAX_IDX_BITS   = 3;
  localparam int DEF_H_BITWIDTH = 9;
  localparam int DEF_V_BITWIDTH = 9;

  // Lowest-numbered set bit wins; an all-zero vector encodes as 0.
  function automatic logic [MAX_IDX_BITS-1:0] prio_enc(input logic [MAX_SPOTS-1:0] v);
    logic [MAX_IDX_BITS-1:0] idx;
    idx = '0;
    for (int i = MAX_SPOTS-1; i >= 0; i--)
      if (v[i]) idx = MAX_IDX_BITS'(i);
    return idx;
  endfunction

endpackage

// File: rtl/spot_window_cmp.sv
// One spot channel: per-frame shadowed geometry and the registered window compare.
// The window is open on both edges, so a width or height of 0 or 1 never shows.
module spot_window_cmp
  import spot_gen_pkg::*;
#(
  parameter int H_BITWIDTH = DEF_H_BITWIDTH,
  parameter int V_BITWIDTH = DEF_V_BITWIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [H_BITWIDTH-1:0] h_count,
  input  logic [V_BITWIDTH-1:0] v_count,
  input  logic [H_BITWIDTH-1:0] spot_x,
  input  logic [H_BITWIDTH-1:0] spot_w,
  input  logic [V_BITWIDTH-1:0] spot_y,
  input  logic [V_BITWIDTH-1:0] spot_h,
  input  logic                  en,
  output logic                  hit
);

  typedef struct packed {
    logic [H_BITWIDTH-1:0] x;
    logic [H_BITWIDTH-1:0] w;
    logic [V_BITWIDTH-1:0] y;
    logic [V_BITWIDTH-1:0] h;
  } geom_t;

  geom_t             shadow;
  logic [H_BITWIDTH:0] x_end;
  logic [V_BITWIDTH:0] y_end;
  logic              in_win;

  // One extra bit keeps the far edge from wrapping back onto the left of the screen.
  assign x_end  = {1'b0, shadow.x} + {1'b0, shadow.w};
  assign y_end  = {1'b0, shadow.y} + {1'b0, shadow.h};
  assign in_win = (shadow.x < h_count) && ({1'b0, h_count} < x_end) &&
                  (shadow.y < v_count) && ({1'b0, v_count} < y_end);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)           shadow <= '0;
    else if (frame_start) shadow <= '{x: spot_x, w: spot_w, y: spot_y, h: spot_h};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hit <= 1'b0;
    else        hit <= en & in_win;
  end

endmodule

// File: rtl/spot_generator_array.sv
// Multi-channel rectangular spot generator: per-channel window compare, registered
// video/priority outputs, and per-frame collision flags for the ball-bounce logic.
module spot_generator_array
  import spot_gen_pkg::*;
#(
  parameter int NUM_SPOTS  = 4,
  parameter int H_BITWIDTH = DEF_H_BITWIDTH,
  parameter int V_BITWIDTH = DEF_V_BITWIDTH,
  parameter int IDX_BITS   = (NUM_SPOTS > 1) ? $clog2(NUM_SPOTS) : 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            frame_start,
  input  logic [H_BITWIDTH-1:0]           h_count,
  input  logic [V_BITWIDTH-1:0]           v_count,
  input  logic [NUM_SPOTS*H_BITWIDTH-1:0] spot_x,
  input  logic [NUM_SPOTS*H_BITWIDTH-1:0] spot_w,
  input  logic [NUM_SPOTS*V_BITWIDTH-1:0] spot_y,
  input  logic [NUM_SPOTS*V_BITWIDTH-1:0] spot_h,
  input  logic [NUM_SPOTS-1:0]            spot_en,
  input  logic                            out_en,
  output logic [NUM_SPOTS-1:0]            spot_out,
  output logic                            video_out,
  output logic [IDX_BITS-1:0]             active_idx,
  output logic [NUM_SPOTS-1:0]            collision
);

  logic [NUM_SPOTS-1:0] hit;
  logic [NUM_SPOTS-1:0] overlap;
  logic [NUM_SPOTS-1:0] sticky;

  for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_spot
    spot_window_cmp #(
      .H_BITWIDTH(H_BITWIDTH),
      .V_BITWIDTH(V_BITWIDTH)
    ) u_cmp (
      .clk        (clk),
      .reset      (reset),
      .frame_start(frame_start),
      .h_count    (h_count),
      .v_count    (v_count),
      .spot_x     (spot_x[i*H_BITWIDTH +: H_BITWIDTH]),
      .spot_w     (spot_w[i*H_BITWIDTH +: H_BITWIDTH]),
      .spot_y     (spot_y[i*V_BITWIDTH +: V_BITWIDTH]),
      .spot_h     (spot_h[i*V_BITWIDTH +: V_BITWIDTH]),
      .en         (spot_en[i] & out_en),
      .hit        (hit[i])
    );
    // A channel overlaps only when some other channel is lit on the same pixel.
    assign overlap[i] = hit[i] & (|(hit & ~(NUM_SPOTS'(1) << i)));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      spot_out   <= '0;
      video_out  <= 1'b0;
      active_idx <= '0;
    end else begin
      spot_out   <= hit;
      video_out  <= |hit;
      active_idx <= IDX_BITS'(prio_enc(MAX_SPOTS'(hit)));
    end
  end

  // An overlap seen on the frame_start cycle still belongs to the frame that is ending.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sticky    <= '0;
      collision <= '0;
    end else if (frame_start) begin
      collision <= sticky | overlap;
      sticky    <= '0;
    end else begin
      sticky    <= sticky | overlap;
    end
  end

endmodule

// File: tb/tb_spot_generator_array.sv
// Bench for spot_generator_array: directed vector tables, hand-written frame/collision
// sequences, and a randomized run checked against a per-frame behavioural model.
module tb_spot_generator_array;

  localparam int N  = 4;
  localparam int HB = 9;
  localparam int VB = 9;
  localparam int IB = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            frame_start = 1'b0;
  logic            out_en = 1'b0;
  logic [HB-1:0]   h_count = '0;
  logic [VB-1:0]   v_count = '0;
  logic [N*HB-1:0] spot_x = '0, spot_w = '0;
  logic [N*VB-1:0] spot_y = '0, spot_h = '0;
  logic [N-1:0]    spot_en = '0;
  logic [N-1:0]    spot_out, collision;
  logic            video_out;
  logic [IB-1:0]   active_idx;

  always #5 clk = ~clk;

  spot_generator_array #(.NUM_SPOTS(N), .H_BITWIDTH(HB), .V_BITWIDTH(VB), .IDX_BITS(IB)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .h_count(h_count), .v_count(v_count),
    .spot_x(spot_x), .spot_w(spot_w), .spot_y(spot_y), .spot_h(spot_h), .spot_en(spot_en),
    .out_en(out_en), .spot_out(spot_out), .video_out(video_out), .active_idx(active_idx),
    .collision(collision)
  );

  int n_vec = 0, n_err = 0;

  // Model: geometry latched at each frame boundary, the set of lit spots one clock
  // behind the beam, the set of spots that shared a pixel so far this frame, and the
  // collision set reported for the previous frame.
  int           fx[N], fw[N], fy[N], fh[N];
  logic [N-1:0] m_lit, m_seen, m_coll;

  typedef struct {
    int   h;
    int   v;
    logic exp;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] lit_now();
    logic [N-1:0] r;
    int hc, vc;
    r  = '0;
    hc = int'(h_count);
    vc = int'(v_count);
    for (int i = 0; i < N; i++)
      r[i] = spot_en[i] && out_en && (fx[i] < hc) && (hc < fx[i] + fw[i]) &&
             (fy[i] < vc) && (vc < fy[i] + fh[i]);
    return r;
  endfunction

  function automatic logic [N-1:0] sharing(input logic [N-1:0] lit);
    return ($countones(lit) > 1) ? lit : '0;
  endfunction

  function automatic logic [IB-1:0] lowest(input logic [N-1:0] lit);
    for (int i = 0; i < N; i++)
      if (lit[i]) return IB'(i);
    return '0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin fx[i] = 0; fw[i] = 0; fy[i] = 0; fh[i] = 0; end
    m_lit = '0; m_seen = '0; m_coll = '0;
  endtask

  // One clock: predict, advance, then compare every output with the model.
  task automatic step();
    logic [N-1:0] nxt;
    nxt = lit_now();
    if (frame_start) begin
      m_coll = m_seen | sharing(m_lit);
      m_seen = '0;
      for (int i = 0; i < N; i++) begin
        fx[i] = int'(spot_x[i*HB +: HB]); fw[i] = int'(spot_w[i*HB +: HB]);
        fy[i] = int'(spot_y[i*VB +: VB]); fh[i] = int'(spot_h[i*VB +: VB]);
      end
    end else begin
      m_seen = m_seen | sharing(m_lit);
    end
    @(posedge clk);
    #1;
    check("outputs", {spot_out, video_out, active_idx, collision},
          {m_lit, |m_lit, lowest(m_lit), m_coll});
    m_lit = nxt;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic set_spot(input int i, input int x, input int w, input int y, input int h);
    spot_x[i*HB +: HB] = HB'(x); spot_w[i*HB +: HB] = HB'(w);
    spot_y[i*VB +: VB] = VB'(y); spot_h[i*VB +: VB] = VB'(h);
  endtask

  task automatic add(input int h, input int v, input logic exp);
    vec_t e;
    e.h = h; e.v = v; e.exp = exp;
    tbl.push_back(e);
  endtask

  // Apply a table of beam positions; spot_out[0] for entry i is due two clocks after it.
  task automatic run_table(input string name);
    for (int i = 0; i <= tbl.size(); i++) begin
      if (i < tbl.size()) begin
        h_count = HB'(tbl[i].h);
        v_count = VB'(tbl[i].v);
      end
      step();
      if (i > 0) check(name, spot_out[0], tbl[i-1].exp);
    end
    tbl.delete();
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_state", {spot_out, video_out, active_idx, collision}, '0);
    reset = 1'b1;
    steps(2);

    // Single spot, visible for h in (10,14) on line 21.
    set_spot(0, 10, 4, 20, 3);
    spot_en = 4'b0001; out_en = 1'b1; v_count = 9'd21;
    frame_pulse();
    for (int h = 0; h <= 20; h++) add(h, 21, (h >= 11 && h <= 13));
    run_table("sweep_x10");

    // A mid-frame move only shows after the next frame boundary.
    set_spot(0, 50, 4, 20, 3);
    for (int h = 0; h <= 20; h++) add(h, 21, (h >= 11 && h <= 13));
    run_table("midframe_old");
    frame_pulse();
    for (int h = 45; h <= 60; h++) add(h, 21, (h >= 51 && h <= 53));
    run_table("nextframe_x50");

    // Right-edge spot must not wrap onto the left of the line; width 1 never shows.
    set_spot(0, 511, 4, 20, 3);
    frame_pulse();
    for (int h = 0; h <= 3; h++) add(h, 21, 1'b0);
    for (int h = 508; h <= 511; h++) add(h, 21, 1'b0);
    run_table("no_wrap");
    set_spot(0, 10, 1, 20, 3);
    frame_pulse();
    for (int h = 8; h <= 13; h++) add(h, 21, 1'b0);
    run_table("width_one");

    // Spots 1 and 2 overlap around (30,40): both flagged for the whole next frame.
    set_spot(1, 28, 5, 38, 5);
    set_spot(2, 29, 4, 39, 3);
    spot_en = 4'b0110;
    frame_pulse();
    v_count = 9'd40;
    for (int h = 25; h <= 35; h++) begin h_count = HB'(h); step(); end
    frame_pulse();
    check("coll_set", collision, 4'b0110);
    v_count = 9'd100;
    for (int h = 0; h < 10; h++) begin h_count = HB'(h); step(); end
    check("coll_hold", collision, 4'b0110);
    frame_pulse();
    check("coll_clear", collision, 4'b0000);

    // Spots 1 and 3 on the same pixel: lowest index wins the priority output.
    set_spot(1, 60, 5, 60, 5);
    set_spot(3, 60, 5, 60, 5);
    spot_en = 4'b1010;
    frame_pulse();
    h_count = 9'd62; v_count = 9'd62;
    steps(3);
    check("prio_pixel", {spot_out, video_out, active_idx}, {4'b1010, 1'b1, 2'd1});
    h_count = 9'd0;
    steps(2);
    frame_pulse();
    check("coll_13", collision, 4'b1010);

    // Blanked or disabled spots contribute neither video nor collisions.
    out_en = 1'b0; h_count = 9'd62;
    steps(3);
    check("blanked", {spot_out, video_out}, 5'b0);
    spot_en = 4'b1000; out_en = 1'b1;
    steps(3);
    check("single_en", spot_out, 4'b1000);
    h_count = 9'd0;
    steps(2);
    frame_pulse();
    check("coll_none", collision, 4'b0000);

    // Asynchronous reset mid-frame clears everything before the next edge.
    spot_en = 4'b1010; h_count = 9'd62;
    steps(3);
    reset = 1'b0;
    #2;
    check("async_reset", {spot_out, video_out, active_idx, collision}, '0);
    model_reset();
    steps(2);
    reset = 1'b1;
    steps(3);
    check("post_reset_dark", spot_out, 4'b0000);
    frame_pulse();
    steps(3);

    // Randomized beam, geometry, enables and frame boundaries.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < N; i++)
          set_spot(i, ($urandom_range(0, 15) == 0) ? $urandom_range(500, 511) : $urandom_range(0, 40),
                   $urandom_range(0, 16), $urandom_range(0, 40), $urandom_range(0, 16));
      end
      spot_en     = N'($urandom);
      out_en      = ($urandom_range(0, 7) != 0);
      frame_start = ($urandom_range(0, 31) == 0);
      h_count     = ($urandom_range(0, 15) == 0) ? HB'($urandom) : HB'($urandom_range(0, 60));
      v_count     = VB'($urandom_range(0, 60));
      step();
    end
    frame_start = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
